// File: rtl/io_pkg.sv
// Shared constants and state encoding for the I/O request arbiter.
package io_pkg;

   localparam int unsigned NUM_IO_DEV = 16;
   localparam int unsigned IO_ADDR_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } io_state_e;

   // One-hot word for a device index.
   function automatic logic [NUM_IO_DEV-1:0] io_onehot(input logic [IO_ADDR_W-1:0] idx);
      return NUM_IO_DEV'(1) << idx;
   endfunction

endpackage

// File: rtl/io_request_arbiter_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping 15->0.
module rr_pick
   import io_pkg::*;
(
   input  logic [NUM_IO_DEV-1:0] req,
   input  logic [IO_ADDR_W-1:0]  ptr,
   output logic [IO_ADDR_W-1:0]  idx,
   output logic                  valid
);

   logic [NUM_IO_DEV-1:0] rot;
   logic [IO_ADDR_W-1:0]  off;

   // Rotate so that bit 0 of rot is the device at ptr; 4-bit index math wraps.
   always_comb begin
      rot = '0;
      for (int i = 0; i < int'(NUM_IO_DEV); i++) begin
         rot[i] = req[IO_ADDR_W'(i) + ptr];
      end
   end

   // Priority encode the lowest set bit of the rotated vector.
   always_comb begin
      off   = '0;
      valid = 1'b0;
      for (int i = int'(NUM_IO_DEV) - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off   = IO_ADDR_W'(i);
            valid = 1'b1;
         end
      end
   end

   assign idx = ptr + off;

endmodule

// File: rtl/io_request_arbiter.sv
// Round-robin arbiter selecting one of 16 I/O devices for the address decoder.
module io_request_arbiter
   import io_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_W           = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_IO_DEV-1:0] io_req,
   input  logic                  bus_free,
   input  logic                  io_ack,
   output logic [IO_ADDR_W-1:0]  io_addr,
   output logic                  io_addr_read,
   output logic [NUM_IO_DEV-1:0] io_grant,
   output logic                  io_busy,
   output logic                  io_timeout
);

   io_state_e            state, state_nxt;
   logic [IO_ADDR_W-1:0] sel, sel_nxt;
   logic [IO_ADDR_W-1:0] ptr, ptr_nxt;
   logic [TO_W-1:0]      cnt, cnt_nxt;
   logic                 abandon, abandon_nxt;

   logic [IO_ADDR_W-1:0]  pick_idx;
   logic                  pick_valid;

   logic                  read_c;
   logic [NUM_IO_DEV-1:0] grant_c;
   logic                  busy_c;
   logic                  timeout_c;

   rr_pick u_pick (
      .req   (io_req),
      .ptr   (ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // FSM and arbitration state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sel     <= '0;
         ptr     <= '0;
         cnt     <= '0;
         abandon <= 1'b0;
      end else begin
         state   <= state_nxt;
         sel     <= sel_nxt;
         ptr     <= ptr_nxt;
         cnt     <= cnt_nxt;
         abandon <= abandon_nxt;
      end
   end

   // Next-state logic; ack takes priority over the timeout in DRIVE.
   always_comb begin
      state_nxt   = state;
      sel_nxt     = sel;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      abandon_nxt = abandon;
      unique case (state)
         IDLE: begin
            cnt_nxt     = '0;
            abandon_nxt = 1'b0;
            if (bus_free && pick_valid) begin
               sel_nxt   = pick_idx;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            cnt_nxt = cnt + TO_W'(1);
            if (io_ack) begin
               state_nxt   = TURN;
               ptr_nxt     = sel + IO_ADDR_W'(1);
               abandon_nxt = 1'b0;
            end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt   = TURN;
               ptr_nxt     = sel + IO_ADDR_W'(1);
               abandon_nxt = 1'b1;
            end
         end
         TURN: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode of the current state, registered below.
   always_comb begin
      read_c    = (state == DRIVE);
      grant_c   = read_c ? io_onehot(sel) : '0;
      busy_c    = (state != IDLE);
      timeout_c = (state == TURN) && abandon;
   end

   // Output register; io_addr keeps the last selection after the grant ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_addr      <= '0;
         io_addr_read <= 1'b0;
         io_grant     <= '0;
         io_busy      <= 1'b0;
         io_timeout   <= 1'b0;
      end else begin
         io_addr      <= sel;
         io_addr_read <= read_c;
         io_grant     <= grant_c;
         io_busy      <= busy_c;
         io_timeout   <= timeout_c;
      end
   end

endmodule
